score_counter_bcd: RTL and testbench



---
 rtl/score_pkg.sv | 24 ++
 rtl/bcd_digit.sv | 36 +++
 rtl/score_counter_bcd.sv | 90 +++++++++
 tb/tb_score_counter_bcd.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and seven-segment decode helpers for the BCD score counter.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Patterns are active-high, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] SEG_PATTERNS [10] = '{
        SEG_ZERO, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    function automatic logic [6:0] bcd_to_seg(input bcd_digit_t digit, input logic active_low);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        if (digit <= 4'd9) begin
            pattern = SEG_PATTERNS[digit];
        end
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the score: counts 0..9 when carry_in is high, passes carry on 9.
module bcd_digit
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       carry_in,
    output bcd_digit_t value,
    output logic       carry_out
);

    bcd_digit_t value_q;
    bcd_digit_t value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = 4'd0;
        end else if (carry_in) begin
            value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value     = value_q;
    assign carry_out = carry_in && (value_q == 4'd9);

endmodule

// File: rtl/score_counter_bcd.sv
// Multi-digit BCD score counter with seven-segment drive, wrap/saturate and overflow.
// Optional high-score register enabled by defining SCORE_HIGH_SCORE_EN.
module score_counter_bcd
    import score_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter bit WRAP           = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      incr,
    input  logic                      clear,
`ifdef SCORE_HIGH_SCORE_EN
    input  logic                      game_over,
`endif
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic [7*NUM_DIGITS-1:0]   seg,
`ifdef SCORE_HIGH_SCORE_EN
    output logic [4*NUM_DIGITS-1:0]   hs_bcd,
    output logic [7*NUM_DIGITS-1:0]   hs_seg,
`endif
    output logic                      overflow,
    output logic                      at_max
);

    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] digit_nine;
    logic                  overflow_q;
    logic                  overflow_d;

    // In saturate mode an increment at all-nines is simply swallowed here.
    assign carry[0] = incr && (WRAP || !at_max);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .carry_in  (carry[i]),
            .value     (bcd[4*i +: 4]),
            .carry_out (carry[i+1])
        );
        assign digit_nine[i]  = (bcd[4*i +: 4] == 4'd9);
        assign seg[7*i +: 7]  = bcd_to_seg(bcd[4*i +: 4], SEG_ACTIVE_LOW);
    end

    assign at_max = &digit_nine;

    // Carry out of the top digit means the score just wrapped to zero.
    assign overflow_d = WRAP && carry[NUM_DIGITS] && !clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef SCORE_HIGH_SCORE_EN
    logic [4*NUM_DIGITS-1:0] hs_q;
    logic [4*NUM_DIGITS-1:0] hs_d;

    // Valid BCD compares correctly as a plain unsigned vector, MSD first.
    always_comb begin
        hs_d = hs_q;
        if (game_over && (bcd > hs_q)) begin
            hs_d = bcd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q <= '0;
        end else begin
            hs_q <= hs_d;
        end
    end

    assign hs_bcd = hs_q;

    for (genvar j = 0; j < NUM_DIGITS; j++) begin : g_hs_seg
        assign hs_seg[7*j +: 7] = bcd_to_seg(hs_q[4*j +: 4], SEG_ACTIVE_LOW);
    end
`endif

endmodule

// File: tb/tb_score_counter_bcd.sv
// Directed self-checking bench for score_counter_bcd: a wrapping active-low instance
// and a saturating active-high instance driven by the same stimulus.
module tb_score_counter_bcd;

    logic        clk;
    logic        reset;
    logic        incr;
    logic        clear;
    logic [11:0] bcd;
    logic [20:0] seg;
    logic        overflow;
    logic        at_max;
    logic [11:0] bcdSat;
    logic [20:0] segSat;
    logic        overflowSat;
    logic        atMaxSat;
`ifdef SCORE_HIGH_SCORE_EN
    logic        gameOver;
    logic [11:0] hsBcd;
    logic [20:0] hsSeg;
    logic [11:0] hsBcdSat;
    logic [20:0] hsSegSat;
`endif

    int checks = 0;
    int errors = 0;

    score_counter_bcd #(.NUM_DIGITS(3), .WRAP(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .incr      (incr),
        .clear     (clear),
`ifdef SCORE_HIGH_SCORE_EN
        .game_over (gameOver),
`endif
        .bcd       (bcd),
        .seg       (seg),
`ifdef SCORE_HIGH_SCORE_EN
        .hs_bcd    (hsBcd),
        .hs_seg    (hsSeg),
`endif
        .overflow  (overflow),
        .at_max    (at_max)
    );

    score_counter_bcd #(.NUM_DIGITS(3), .WRAP(1'b0), .SEG_ACTIVE_LOW(1'b0)) dutSat (
        .clk       (clk),
        .reset     (reset),
        .incr      (incr),
        .clear     (clear),
`ifdef SCORE_HIGH_SCORE_EN
        .game_over (gameOver),
`endif
        .bcd       (bcdSat),
        .seg       (segSat),
`ifdef SCORE_HIGH_SCORE_EN
        .hs_bcd    (hsBcdSat),
        .hs_seg    (hsSegSat),
`endif
        .overflow  (overflowSat),
        .at_max    (atMaxSat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [11:0] toBcd(input int k);
        return {4'(k / 100), 4'((k / 10) % 10), 4'(k % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runIncr(input int n);
        incr = 1'b1;
        repeat (n) tick();
        incr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        incr  = 1'b0;
        clear = 1'b0;
        repeat (3) tick();
        checks++;
        if (bcd !== 12'h000) begin errors++; $display("[TB] FAIL reset_bcd: got %h expected 000", bcd); end
        checks++;
        if (seg !== {7'b1000000, 7'b1000000, 7'b1000000}) begin errors++; $display("[TB] FAIL reset_seg: got %b expected 1000000 x3", seg); end
        checks++;
        if (segSat !== {7'b0111111, 7'b0111111, 7'b0111111}) begin errors++; $display("[TB] FAIL reset_seg_high: got %b expected 0111111 x3", segSat); end
        checks++;
        if (at_max !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got at_max=%b overflow=%b expected 0 0", at_max, overflow); end
        reset = 1'b0;
    endtask

    task automatic test_count();
        incr = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (bcd !== toBcd(k)) begin errors++; $display("[TB] FAIL count_%0d: got %h expected %h", k, bcd, toBcd(k)); end
            if (k == 7) begin
                checks++;
                if (seg[6:0] !== 7'b1111000) begin errors++; $display("[TB] FAIL seg_seven: got %b expected 1111000", seg[6:0]); end
            end
        end
        incr = 1'b0;
        checks++;
        if (seg !== {7'b1000000, 7'b1111001, 7'b0010010}) begin errors++; $display("[TB] FAIL seg_015: got %b", seg); end
    endtask

    task automatic test_carry();
        runIncr(84);
        checks++;
        if (bcd !== 12'h099) begin errors++; $display("[TB] FAIL preload_099: got %h expected 099", bcd); end
        incr = 1'b1;
        tick();
        incr = 1'b0;
        checks++;
        if (bcd !== 12'h100) begin errors++; $display("[TB] FAIL ripple_100: got %h expected 100", bcd); end
        checks++;
        if (seg !== {7'b1111001, 7'b1000000, 7'b1000000}) begin errors++; $display("[TB] FAIL seg_100: got %b", seg); end
        tick();
        checks++;
        if (bcd !== 12'h100) begin errors++; $display("[TB] FAIL hold_100: got %h expected 100", bcd); end
    endtask

    task automatic test_wrap();
        runIncr(899);
        checks++;
        if (bcd !== 12'h999 || at_max !== 1'b1) begin errors++; $display("[TB] FAIL reach_999: got %h at_max=%b expected 999 1", bcd, at_max); end
        checks++;
        if (seg !== {7'b0010000, 7'b0010000, 7'b0010000}) begin errors++; $display("[TB] FAIL seg_999: got %b", seg); end
        checks++;
        if (segSat !== {7'b1101111, 7'b1101111, 7'b1101111}) begin errors++; $display("[TB] FAIL seg_999_high: got %b", segSat); end
        incr = 1'b1;
        tick();
        incr = 1'b0;
        checks++;
        if (bcd !== 12'h000 || overflow !== 1'b1 || at_max !== 1'b0) begin errors++; $display("[TB] FAIL wrap_edge: got bcd=%h ov=%b at_max=%b expected 000 1 0", bcd, overflow, at_max); end
        checks++;
        if (bcdSat !== 12'h999 || overflowSat !== 1'b0 || atMaxSat !== 1'b1) begin errors++; $display("[TB] FAIL saturate_edge: got bcd=%h ov=%b at_max=%b expected 999 0 1", bcdSat, overflowSat, atMaxSat); end
        tick();
        checks++;
        if (overflow !== 1'b0 || bcd !== 12'h000) begin errors++; $display("[TB] FAIL wrap_pulse_end: got bcd=%h ov=%b expected 000 0", bcd, overflow); end
    endtask

    task automatic test_clear();
        runIncr(42);
        checks++;
        if (bcd !== 12'h042) begin errors++; $display("[TB] FAIL preload_042: got %h expected 042", bcd); end
        checks++;
        if (bcdSat !== 12'h999 || overflowSat !== 1'b0) begin errors++; $display("[TB] FAIL saturate_hold: got %h ov=%b expected 999 0", bcdSat, overflowSat); end
        clear = 1'b1;
        incr  = 1'b1;
        tick();
        clear = 1'b0;
        incr  = 1'b0;
        checks++;
        if (bcd !== 12'h000 || bcdSat !== 12'h000 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL clear_incr: got %h %h ov=%b expected 000 000 0", bcd, bcdSat, overflow); end
        runIncr(999);
        clear = 1'b1;
        incr  = 1'b1;
        tick();
        clear = 1'b0;
        incr  = 1'b0;
        checks++;
        if (bcd !== 12'h000 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL clear_at_max: got bcd=%h ov=%b expected 000 0", bcd, overflow); end
    endtask

    task automatic test_reset_mid();
        int expected;
        incr = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            reset = (c == 10);
            tick();
            expected = (c < 10) ? c : c - 10;
            checks++;
            if (bcd !== toBcd(expected) || overflow !== 1'b0) begin errors++; $display("[TB] FAIL burst_%0d: got bcd=%h ov=%b expected %h 0", c, bcd, overflow, toBcd(expected)); end
        end
        reset = 1'b0;
        incr  = 1'b0;
        runIncr(989);
        checks++;
        if (bcd !== 12'h999) begin errors++; $display("[TB] FAIL reach_999_again: got %h expected 999", bcd); end
        reset = 1'b1;
        incr  = 1'b1;
        tick();
        reset = 1'b0;
        incr  = 1'b0;
        checks++;
        if (bcd !== 12'h000 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_cancels_wrap: got bcd=%h ov=%b expected 000 0", bcd, overflow); end
        tick();
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL no_late_pulse: got ov=%b expected 0", overflow); end
    endtask

`ifdef SCORE_HIGH_SCORE_EN
    task automatic test_high_score();
        runIncr(36);
        gameOver = 1'b1;
        incr     = 1'b1;
        tick();
        incr     = 1'b0;
        checks++;
        if (bcd !== 12'h037 || hsBcd !== 12'h036) begin errors++; $display("[TB] FAIL hs_pre_incr: got bcd=%h hs=%h expected 037 036", bcd, hsBcd); end
        tick();
        gameOver = 1'b0;
        checks++;
        if (hsBcd !== 12'h037) begin errors++; $display("[TB] FAIL hs_capture: got %h expected 037", hsBcd); end
        checks++;
        if (hsSeg !== {7'b1000000, 7'b0110000, 7'b1111000}) begin errors++; $display("[TB] FAIL hs_seg: got %b", hsSeg); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (bcd !== 12'h000 || hsBcd !== 12'h037) begin errors++; $display("[TB] FAIL hs_after_clear: got bcd=%h hs=%h expected 000 037", bcd, hsBcd); end
        runIncr(12);
        gameOver = 1'b1;
        tick();
        gameOver = 1'b0;
        checks++;
        if (bcd !== 12'h012 || hsBcd !== 12'h037) begin errors++; $display("[TB] FAIL hs_keep_higher: got bcd=%h hs=%h expected 012 037", bcd, hsBcd); end
    endtask
`endif

    initial begin
        $display("[TB] score_counter_bcd bench starting");
`ifdef SCORE_HIGH_SCORE_EN
        gameOver = 1'b0;
`endif
        test_reset();
        test_count();
        test_carry();
        test_wrap();
        test_clear();
        test_reset_mid();
`ifdef SCORE_HIGH_SCORE_EN
        test_high_score();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
